tl_channel_buffer: RTL and testbench

- Parametrised TileLink-UL A/D channel buffer, the successor to the fixed single-configuration widget wrapper used between core-side ports and the AXI4 bridge.
- Each direction gets an independent FIFO:
  - A channel runs master to slave.
  - D channel runs slave to master.
- Depth, data width, address width and source width are all set by parameters.
- Occupancy outputs and an idle flag are provided for clock-gating and drain logic.

---
 rtl/tl_buf_pkg.sv | 69 ++++++
 rtl/tl_channel_buffer_if.sv | 44 ++++
 rtl/tl_buf_queue.sv | 82 ++++++++
 rtl/tl_channel_buffer.sv | 49 ++++
 tb/tb_tl_channel_buffer.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tl_buf_pkg.sv
// Shared TileLink-UL definitions for the A/D channel buffer: opcodes, beat widths,
// field offsets and beat structs for the default bus configuration.
package tl_buf_pkg;

   localparam logic [2:0] A_GET             = 3'd4;
   localparam logic [2:0] A_PUT_FULL        = 3'd0;
   localparam logic [2:0] A_PUT_PARTIAL     = 3'd1;
   localparam logic [2:0] D_ACCESS_ACK      = 3'd0;
   localparam logic [2:0] D_ACCESS_ACK_DATA = 3'd1;

   function automatic int A_W(input int data_w, input int addr_w, input int src_w, input int size_w);
      return 3 + 3 + size_w + src_w + addr_w + data_w / 8 + data_w + 1;
   endfunction

   function automatic int D_W(input int data_w, input int src_w, input int size_w);
      return 3 + 2 + size_w + src_w + 1 + 1 + data_w + 1;
   endfunction

   // Occupancy counters stay at least one bit wide so a passthrough channel still has a port.
   function automatic int cnt_w(input int depth);
      return (depth > 0) ? $clog2(depth + 1) : 1;
   endfunction

   localparam int DEF_DATA_W = 64;
   localparam int DEF_ADDR_W = 30;
   localparam int DEF_SRC_W  = 7;
   localparam int DEF_SIZE_W = 4;

   localparam int A_CORRUPT_LSB = 0;
   localparam int A_DATA_LSB    = 1;
   localparam int A_MASK_LSB    = A_DATA_LSB + DEF_DATA_W;
   localparam int A_ADDR_LSB    = A_MASK_LSB + DEF_DATA_W / 8;
   localparam int A_SRC_LSB     = A_ADDR_LSB + DEF_ADDR_W;
   localparam int A_SIZE_LSB    = A_SRC_LSB + DEF_SRC_W;
   localparam int A_PARAM_LSB   = A_SIZE_LSB + DEF_SIZE_W;
   localparam int A_OPCODE_LSB  = A_PARAM_LSB + 3;

   localparam int D_CORRUPT_LSB = 0;
   localparam int D_DATA_LSB    = 1;
   localparam int D_DENIED_LSB  = D_DATA_LSB + DEF_DATA_W;
   localparam int D_SINK_LSB    = D_DENIED_LSB + 1;
   localparam int D_SRC_LSB     = D_SINK_LSB + 1;
   localparam int D_SIZE_LSB    = D_SRC_LSB + DEF_SRC_W;
   localparam int D_PARAM_LSB   = D_SIZE_LSB + DEF_SIZE_W;
   localparam int D_OPCODE_LSB  = D_PARAM_LSB + 2;

   typedef struct packed {
      logic [2:0]                opcode;
      logic [2:0]                param;
      logic [DEF_SIZE_W-1:0]     size;
      logic [DEF_SRC_W-1:0]      source;
      logic [DEF_ADDR_W-1:0]     address;
      logic [DEF_DATA_W/8-1:0]   mask;
      logic [DEF_DATA_W-1:0]     data;
      logic                      corrupt;
   } a_beat_t;

   typedef struct packed {
      logic [2:0]                opcode;
      logic [1:0]                param;
      logic [DEF_SIZE_W-1:0]     size;
      logic [DEF_SRC_W-1:0]      source;
      logic                      sink;
      logic                      denied;
      logic [DEF_DATA_W-1:0]     data;
      logic                      corrupt;
   } d_beat_t;

endpackage

// File: rtl/tl_channel_buffer_if.sv
// A/D handshake bundle for tl_channel_buffer; master is the environment side,
// slave is the buffer itself.
interface tl_channel_buffer_if #(
   parameter int DATA_W  = 64,
   parameter int ADDR_W  = 30,
   parameter int SRC_W   = 7,
   parameter int SIZE_W  = 4,
   parameter int A_DEPTH = 2,
   parameter int D_DEPTH = 2
);
   import tl_buf_pkg::*;

   localparam int AW = A_W(DATA_W, ADDR_W, SRC_W, SIZE_W);
   localparam int DW = D_W(DATA_W, SRC_W, SIZE_W);

   logic                        in_a_valid;
   logic                        in_a_ready;
   logic [AW-1:0]               in_a_bits;
   logic                        out_a_valid;
   logic                        out_a_ready;
   logic [AW-1:0]               out_a_bits;
   logic                        in_d_valid;
   logic                        in_d_ready;
   logic [DW-1:0]               in_d_bits;
   logic                        out_d_valid;
   logic                        out_d_ready;
   logic [DW-1:0]               out_d_bits;
   logic [cnt_w(A_DEPTH)-1:0]   a_count;
   logic [cnt_w(D_DEPTH)-1:0]   d_count;
   logic                        idle;

   modport master (
      output in_a_valid, in_a_bits, out_a_ready, in_d_valid, in_d_bits, out_d_ready,
      input  in_a_ready, out_a_valid, out_a_bits, in_d_ready, out_d_valid, out_d_bits,
      input  a_count, d_count, idle
   );

   modport slave (
      input  in_a_valid, in_a_bits, out_a_ready, in_d_valid, in_d_bits, out_d_ready,
      output in_a_ready, out_a_valid, out_a_bits, in_d_ready, out_d_valid, out_d_bits,
      output a_count, d_count, idle
   );

endinterface

// File: rtl/tl_buf_queue.sv
// Generic valid/ready FIFO, modulo-DEPTH pointers, DEPTH=0 is a wire; 1-cycle latency,
// or 0 when empty with TL_CHANNEL_BUFFER_FLOW_EN. in_ready drops only when full.
module tl_buf_queue
   import tl_buf_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 2
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [WIDTH-1:0]          in_bits,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [WIDTH-1:0]          out_bits,
   output logic [cnt_w(DEPTH)-1:0]   count
);

   generate
      if (DEPTH == 0) begin : g_pass
         assign out_valid = in_valid;
         assign in_ready  = out_ready;
         assign out_bits  = in_bits;
         assign count     = '0;
      end else begin : g_fifo
         localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
         localparam int CW    = cnt_w(DEPTH);

         logic [WIDTH-1:0] mem [DEPTH];
         logic [PTR_W-1:0] wr_ptr;
         logic [PTR_W-1:0] rd_ptr;
         logic [CW-1:0]    cnt;
         logic             empty;
         logic             push;
         logic             pop;

         // Wrap at DEPTH-1 so non-power-of-two depths use every entry.
         function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
            return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
         endfunction

         assign empty    = (cnt == '0);
         assign in_ready = (cnt < CW'(DEPTH));
         assign count    = cnt;

`ifdef TL_CHANNEL_BUFFER_FLOW_EN
         // Empty queue presents the incoming beat directly; taken the same cycle, it never lands.
         assign out_valid = !empty || in_valid;
         assign out_bits  = empty ? in_bits : mem[rd_ptr];
         assign push      = in_valid && in_ready && !(empty && out_ready);
         assign pop       = out_valid && out_ready && !empty;
`else
         assign out_valid = !empty;
         assign out_bits  = mem[rd_ptr];
         assign push      = in_valid && in_ready;
         assign pop       = out_valid && out_ready;
`endif

         always_ff @(posedge clock) begin
            if (reset) begin
               wr_ptr <= '0;
               rd_ptr <= '0;
               cnt    <= '0;
            end else begin
               if (push) wr_ptr <= ptr_inc(wr_ptr);
               if (pop)  rd_ptr <= ptr_inc(rd_ptr);
               case ({push, pop})
                  2'b10:   cnt <= cnt + 1'b1;
                  2'b01:   cnt <= cnt - 1'b1;
                  default: cnt <= cnt;
               endcase
            end
         end

         always_ff @(posedge clock) begin
            if (push && !reset) mem[wr_ptr] <= in_bits;
         end
      end
   endgenerate

endmodule

// File: rtl/tl_channel_buffer.sv
// TileLink-UL A/D channel buffer: independent FIFO per direction plus idle flag.
// Latency 1 cycle (0 when empty with TL_CHANNEL_BUFFER_FLOW_EN); in_*_ready low only when full.
module tl_channel_buffer
   import tl_buf_pkg::*;
#(
   parameter int DATA_W  = 64,
   parameter int ADDR_W  = 30,
   parameter int SRC_W   = 7,
   parameter int SIZE_W  = 4,
   parameter int A_DEPTH = 2,
   parameter int D_DEPTH = 2
) (
   input  logic               clock,
   input  logic               reset,
   tl_channel_buffer_if.slave bus
);

   localparam int AW = A_W(DATA_W, ADDR_W, SRC_W, SIZE_W);
   localparam int DW = D_W(DATA_W, SRC_W, SIZE_W);

   tl_buf_queue #(.WIDTH(AW), .DEPTH(A_DEPTH)) u_a_queue (
      .clock     (clock),
      .reset     (reset),
      .in_valid  (bus.in_a_valid),
      .in_ready  (bus.in_a_ready),
      .in_bits   (bus.in_a_bits),
      .out_valid (bus.out_a_valid),
      .out_ready (bus.out_a_ready),
      .out_bits  (bus.out_a_bits),
      .count     (bus.a_count)
   );

   tl_buf_queue #(.WIDTH(DW), .DEPTH(D_DEPTH)) u_d_queue (
      .clock     (clock),
      .reset     (reset),
      .in_valid  (bus.in_d_valid),
      .in_ready  (bus.in_d_ready),
      .in_bits   (bus.in_d_bits),
      .out_valid (bus.out_d_valid),
      .out_ready (bus.out_d_ready),
      .out_bits  (bus.out_d_bits),
      .count     (bus.d_count)
   );

   // Pending inputs count as activity so a gated clock wakes before the beat is lost.
   assign bus.idle = (bus.a_count == '0) && (bus.d_count == '0) &&
                     !bus.in_a_valid && !bus.in_d_valid;

endmodule

// File: tb/tb_tl_channel_buffer.sv
// Randomised and directed bench for tl_channel_buffer with a queue-based reference
// model, an output scoreboard and held-valid checks.
module tb_tl_channel_buffer;
   import tl_buf_pkg::*;

   localparam int AD = 2;
   localparam int DD = 3;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   tl_channel_buffer_if #(.A_DEPTH(AD), .D_DEPTH(DD)) bus ();

   tl_channel_buffer #(.A_DEPTH(AD), .D_DEPTH(DD)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;

   a_beat_t exp_a[$];
   d_beat_t exp_d[$];
   int      cnt_a = 0;
   int      cnt_d = 0;
   logic    hold_a = 1'b0, hold_d = 1'b0;
   a_beat_t held_a;
   d_beat_t held_d;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   function automatic a_beat_t mk_a(input logic [2:0] op, input int src, input int addr, input logic [63:0] data);
      a_beat_t b;
      b         = '0;
      b.opcode  = op;
      b.size    = 4'd3;
      b.source  = src[6:0];
      b.address = addr[29:0];
      b.mask    = 8'hFF;
      b.data    = data;
      return b;
   endfunction

   function automatic d_beat_t mk_d(input logic [2:0] op, input int src, input logic [63:0] data);
      d_beat_t b;
      b        = '0;
      b.opcode = op;
      b.size   = 4'd3;
      b.source = src[6:0];
      b.data   = data;
      return b;
   endfunction

   // Reference model: occupancy from accepted/retired beats, expected order from queues.
   always @(negedge clock) begin
      logic acc_a, deq_a, acc_d, deq_d;
      if (reset) begin
         cnt_a = 0; cnt_d = 0;
         exp_a.delete(); exp_d.delete();
         hold_a = 1'b0; hold_d = 1'b0;
      end else begin
         check("a_count", bus.a_count, cnt_a);
         check("d_count", bus.d_count, cnt_d);
         check("in_a_ready", bus.in_a_ready, cnt_a < AD);
         check("in_d_ready", bus.in_d_ready, cnt_d < DD);
`ifdef TL_CHANNEL_BUFFER_FLOW_EN
         check("out_a_valid", bus.out_a_valid, (cnt_a != 0) || bus.in_a_valid);
         check("out_d_valid", bus.out_d_valid, (cnt_d != 0) || bus.in_d_valid);
`else
         check("out_a_valid", bus.out_a_valid, cnt_a != 0);
         check("out_d_valid", bus.out_d_valid, cnt_d != 0);
`endif
         check("idle", bus.idle, (cnt_a == 0) && (cnt_d == 0) && !bus.in_a_valid && !bus.in_d_valid);
         if (hold_a) begin
            check("a_held_valid", bus.out_a_valid, 1);
            check("a_held_bits", bus.out_a_bits, held_a);
         end
         if (hold_d) begin
            check("d_held_valid", bus.out_d_valid, 1);
            check("d_held_bits", bus.out_d_bits, held_d);
         end
         acc_a = bus.in_a_valid && bus.in_a_ready;
         deq_a = bus.out_a_valid && bus.out_a_ready;
         acc_d = bus.in_d_valid && bus.in_d_ready;
         deq_d = bus.out_d_valid && bus.out_d_ready;
         if (acc_a) exp_a.push_back(bus.in_a_bits);
         if (acc_d) exp_d.push_back(bus.in_d_bits);
         cnt_a  = cnt_a + int'(acc_a) - int'(deq_a);
         cnt_d  = cnt_d + int'(acc_d) - int'(deq_d);
         hold_a = bus.out_a_valid && !bus.out_a_ready;
         hold_d = bus.out_d_valid && !bus.out_d_ready;
         held_a = bus.out_a_bits;
         held_d = bus.out_d_bits;
      end
   end

   // Scoreboard monitor: every retired beat must be the oldest expected one.
   always begin
      @(negedge clock);
      #1;
      if (!reset) begin
         if (bus.out_a_valid && bus.out_a_ready) begin
            if (exp_a.size() == 0) begin
               n_checks++; n_fail++;
               $display("FAIL a_unexpected: got %0h, expected no beat", bus.out_a_bits);
            end else check("a_order", bus.out_a_bits, exp_a.pop_front());
         end
         if (bus.out_d_valid && bus.out_d_ready) begin
            if (exp_d.size() == 0) begin
               n_checks++; n_fail++;
               $display("FAIL d_unexpected: got %0h, expected no beat", bus.out_d_bits);
            end else check("d_order", bus.out_d_bits, exp_d.pop_front());
         end
      end
   end

   initial begin
      a_beat_t ta;
      d_beat_t td;
      logic    ok;

      bus.in_a_valid  = 1'b0; bus.in_a_bits = '0; bus.out_a_ready = 1'b0;
      bus.in_d_valid  = 1'b0; bus.in_d_bits = '0; bus.out_d_ready = 1'b0;
      reset = 1'b1;
      repeat (3) tick();
      reset = 1'b0;

      // Reset state
      @(negedge clock);
      check("rst_out_a_valid", bus.out_a_valid, 0);
      check("rst_in_a_ready", bus.in_a_ready, 1);
      check("rst_a_count", bus.a_count, 0);
      check("rst_idle", bus.idle, 1);
      tick();

      // Fill A to capacity, then drain in order
      bus.in_a_valid = 1'b1;
      bus.in_a_bits  = mk_a(A_GET, 5, 'h1000, 64'h0);
      tick();
      bus.in_a_bits  = mk_a(A_PUT_FULL, 6, 'h1008, 64'h1111_2222_3333_4444);
      tick();
      bus.in_a_bits  = mk_a(A_GET, 7, 'h2000, 64'h0);
      @(negedge clock);
      check("full_in_a_ready", bus.in_a_ready, 0);
      check("full_a_count", bus.a_count, 2);
      tick();
      bus.in_a_valid  = 1'b0;
      bus.out_a_ready = 1'b1;
      @(negedge clock);
      ta = bus.out_a_bits;
      check("drain0_src", ta.source, 5);
      tick();
      @(negedge clock);
      ta = bus.out_a_bits;
      check("drain1_valid", bus.out_a_valid, 1);
      check("drain1_src", ta.source, 6);
      tick();
      @(negedge clock);
      check("drained_a_count", bus.a_count, 0);
      tick();

      // D streaming: ten beats through a depth-3 ring
      bus.out_d_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         bus.in_d_valid = 1'b1;
         bus.in_d_bits  = mk_d(D_ACCESS_ACK_DATA, i, 64'(i));
         ok = 1'b0;
         for (int k = 0; k < 20 && !ok; k++) begin
            @(negedge clock);
            ok = bus.in_d_ready;
            tick();
         end
         if (!ok) begin
            n_checks++; n_fail++;
            $display("FAIL d_stream_accept: beat %0d never accepted", i);
         end
      end
      bus.in_d_valid = 1'b0;
      repeat (4) tick();

      // Full A with simultaneous push and pop: head leaves, new beat refused
      bus.out_a_ready = 1'b0;
      bus.in_a_valid  = 1'b1;
      bus.in_a_bits   = mk_a(A_GET, 8, 'h3000, 64'h0);
      tick();
      bus.in_a_bits   = mk_a(A_PUT_PARTIAL, 9, 'h3008, 64'hABCD);
      tick();
      bus.in_a_bits   = mk_a(A_GET, 10, 'h3010, 64'h0);
      bus.out_a_ready = 1'b1;
      @(negedge clock);
      check("pp_in_a_ready", bus.in_a_ready, 0);
      check("pp_out_a_valid", bus.out_a_valid, 1);
      tick();
      bus.in_a_valid  = 1'b0;
      bus.out_a_ready = 1'b0;
      @(negedge clock);
      check("pp_a_count", bus.a_count, 1);
      tick();
      bus.out_a_ready = 1'b1;
      repeat (3) tick();

      // Reset with two queued beats: they must vanish
      bus.out_a_ready = 1'b0;
      bus.in_a_valid  = 1'b1;
      bus.in_a_bits   = mk_a(A_GET, 11, 'h4000, 64'h0);
      tick();
      bus.in_a_bits   = mk_a(A_GET, 12, 'h4008, 64'h0);
      tick();
      bus.in_a_valid  = 1'b0;
      bus.out_a_ready = 1'b1;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      @(negedge clock);
      check("mid_rst_out_a_valid", bus.out_a_valid, 0);
      check("mid_rst_a_count", bus.a_count, 0);
      repeat (3) tick();

      // Empty D queue latency
      bus.out_d_ready = 1'b1;
      bus.in_d_valid  = 1'b1;
      bus.in_d_bits   = mk_d(D_ACCESS_ACK_DATA, 3, 64'hDEAD_BEEF);
      @(negedge clock);
`ifdef TL_CHANNEL_BUFFER_FLOW_EN
      td = bus.out_d_bits;
      check("flow_out_d_valid", bus.out_d_valid, 1);
      check("flow_out_d_data", td.data, 64'hDEAD_BEEF);
      check("flow_d_count", bus.d_count, 0);
`else
      check("lat_out_d_valid0", bus.out_d_valid, 0);
`endif
      tick();
      bus.in_d_valid = 1'b0;
      @(negedge clock);
`ifdef TL_CHANNEL_BUFFER_FLOW_EN
      check("flow_after_d_count", bus.d_count, 0);
`else
      td = bus.out_d_bits;
      check("lat_out_d_valid1", bus.out_d_valid, 1);
      check("lat_out_d_data", td.data, 64'hDEAD_BEEF);
`endif
      tick();

      // Random traffic with occasional resets
      for (int c = 0; c < 3000; c++) begin
         ta = '0;
         ta.opcode  = 3'($urandom_range(0, 2) == 0 ? A_GET : A_PUT_FULL);
         ta.param   = 3'($urandom);
         ta.size    = 4'($urandom);
         ta.source  = 7'($urandom);
         ta.address = 30'($urandom);
         ta.mask    = 8'($urandom);
         ta.data    = {$urandom, $urandom};
         ta.corrupt = 1'($urandom);
         td = '0;
         td.opcode  = 3'($urandom_range(0, 1));
         td.param   = 2'($urandom);
         td.size    = 4'($urandom);
         td.source  = 7'($urandom);
         td.sink    = 1'($urandom);
         td.denied  = 1'($urandom);
         td.data    = {$urandom, $urandom};
         td.corrupt = 1'($urandom);
         bus.in_a_bits   = ta;
         bus.in_d_bits   = td;
         bus.in_a_valid  = ($urandom_range(0, 3) != 0);
         bus.in_d_valid  = ($urandom_range(0, 3) != 0);
         bus.out_a_ready = ($urandom_range(0, 2) != 0);
         bus.out_d_ready = ($urandom_range(0, 2) != 0);
         reset           = ($urandom_range(0, 499) == 0);
         tick();
      end

      // Drain and confirm nothing is left behind
      reset           = 1'b0;
      bus.in_a_valid  = 1'b0;
      bus.in_d_valid  = 1'b0;
      bus.out_a_ready = 1'b1;
      bus.out_d_ready = 1'b1;
      repeat (10) tick();
      check("final_a_empty", exp_a.size(), 0);
      check("final_d_empty", exp_d.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
